register_file_scoreboard: RTL and testbench

//  Parametrised multi-port register file with a hazard scoreboard for the pipelined core.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/register_file_scoreboard_bypass.sv | 36 +++
 rtl/register_file_scoreboard.sv | 99 +++++++++
 tb/tb_register_file_scoreboard.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared parameters, address-width helper and write-port record
// for the register file with hazard scoreboard.
package regfile_pkg;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  localparam int DATA_W_DEF     = 64;
  localparam int NUM_REGS_DEF   = 16;
  localparam int FLAG_INDEX_DEF = 15;
  localparam int AW_DEF         = addr_w(NUM_REGS_DEF);

  typedef struct packed {
    logic                  en;
    logic [AW_DEF-1:0]     addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/register_file_scoreboard_bypass.sv
// Per-read-port operand mux: stored value or same-cycle
// write-back data, later write port taking priority.
module regfile_bypass_mux #(
  parameter int DATA_W   = 64,
  parameter int AW       = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   stored_i,
  input  logic [1:0]          wr_en_i,
  input  logic [2*AW-1:0]     wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                hit_o
);

  logic zero;
  logic hit0;
  logic hit1;

  assign zero = ZERO_REG & (addr_i == '0);
  assign hit0 = wr_en_i[0] & (wr_addr_i[0 +: AW] == addr_i) & ~zero;
  assign hit1 = wr_en_i[1] & (wr_addr_i[AW +: AW] == addr_i) & ~zero;
  assign hit_o = hit0 | hit1;

  always_comb begin
    data_o = stored_i;
    if (zero)
      data_o = '0;
    else if (hit1)
      data_o = wr_data_i[DATA_W +: DATA_W];
    else if (hit0)
      data_o = wr_data_i[0 +: DATA_W];
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// Multi-port register file with write-back bypass and a
// per-register busy scoreboard for issue hazard checks.
module register_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int NUM_READ   = 2,
  parameter int FLAG_INDEX = FLAG_INDEX_DEF,
  parameter bit ZERO_REG   = 1'b0,
  localparam int AW        = addr_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*AW-1:0]     rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_ready,
  input  logic [1:0]                 wr_en,
  input  logic [2*AW-1:0]            wr_addr,
  input  logic [2*DATA_W-1:0]        wr_data,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_addr,
  output logic                       issue_accept,
  output logic [AW:0]                busy_count,
  output logic                       flag
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [AW:0]         count_q;
  logic [AW:0]         count_d;
  logic [AW-1:0]       wa [2];
  logic [1:0]          wr_ok;
  logic                iss_set;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wa[k]    = wr_addr[k*AW +: AW];
      wr_ok[k] = wr_en[k] & ~(ZERO_REG & (wa[k] == '0));
    end
  end

  assign issue_accept = issue_en & ~busy_q[issue_addr];
  assign iss_set = issue_accept & ~(ZERO_REG & (issue_addr == '0));

  // A same-cycle issue re-marks the register busy for the new producer.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++)
      if (wr_ok[k]) busy_d[wa[k]] = 1'b0;
    if (iss_set) busy_d[issue_addr] = 1'b1;
    count_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      count_d = count_d + (AW+1)'(busy_d[r]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (wr_ok[k])
          regs_q[wa[k]] <= wr_data[k*DATA_W +: DATA_W];
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;
  assign flag       = regs_q[FLAG_INDEX][0];

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra = rd_addr[i*AW +: AW];

    regfile_bypass_mux #(
      .DATA_W   (DATA_W),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .addr_i    (ra),
      .stored_i  (regs_q[ra]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .data_o    (rd_data[i*DATA_W +: DATA_W]),
      .hit_o     (hit)
    );

    assign rd_ready[i] = ~busy_q[ra] | hit;
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: two instances (ZERO_REG 0/1)
// on shared stimulus, vector table, corner sequences, random vs model.
module tb_register_file_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   we;
  logic [7:0]   wa;
  logic [127:0] wd;
  logic         ie;
  logic [3:0]   ia;
  logic [7:0]   ra;

  logic [127:0] o_rd  [2];
  logic [1:0]   o_rr  [2];
  logic         o_acc [2];
  logic [4:0]   o_cnt [2];
  logic         o_flg [2];

  int nchk = 0;
  int nerr = 0;

  register_file_scoreboard #(.ZERO_REG(1'b0)) d0 (
    .clk(clk), .reset(rst), .rd_addr(ra), .rd_data(o_rd[0]),
    .rd_ready(o_rr[0]), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .issue_en(ie), .issue_addr(ia), .issue_accept(o_acc[0]),
    .busy_count(o_cnt[0]), .flag(o_flg[0])
  );

  register_file_scoreboard #(.ZERO_REG(1'b1)) d1 (
    .clk(clk), .reset(rst), .rd_addr(ra), .rd_data(o_rd[1]),
    .rd_ready(o_rr[1]), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .issue_en(ie), .issue_addr(ia), .issue_accept(o_acc[1]),
    .busy_count(o_cnt[1]), .flag(o_flg[1])
  );

  // Reference state: register contents and busy flags per instance.
  logic [63:0] mr [2][16];
  bit          mb [2][16];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_read(int z, logic [3:0] a,
                                     output logic [63:0] d,
                                     output logic r);
    if (z == 1 && a == 4'd0) begin
      d = '0; r = 1'b1;
    end else if (we[1] && wa[7:4] == a) begin
      d = wd[127:64]; r = 1'b1;
    end else if (we[0] && wa[3:0] == a) begin
      d = wd[63:0]; r = 1'b1;
    end else begin
      d = mr[z][a]; r = !mb[z][a];
    end
  endfunction

  function automatic logic m_acc(int z);
    return ie && !mb[z][ia];
  endfunction

  function automatic int m_cnt(int z);
    int c = 0;
    for (int r = 0; r < 16; r++) c += int'(mb[z][r]);
    return c;
  endfunction

  task automatic check_all();
    logic [63:0] d;
    logic        r;
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 2; i++) begin
        model_read(z, ra[i*4 +: 4], d, r);
        chk($sformatf("d%0d rd_data%0d", z, i), o_rd[z][i*64 +: 64], d);
        chk($sformatf("d%0d rd_ready%0d", z, i), 64'(o_rr[z][i]), 64'(r));
      end
      chk($sformatf("d%0d issue_accept", z), 64'(o_acc[z]), 64'(m_acc(z)));
      chk($sformatf("d%0d busy_count", z), 64'(o_cnt[z]), 64'(m_cnt(z)));
      chk($sformatf("d%0d flag", z), 64'(o_flg[z]), 64'(mr[z][15][0]));
    end
  endtask

  task automatic model_step();
    bit          acc [2];
    logic [3:0]  a;
    for (int z = 0; z < 2; z++) acc[z] = m_acc(z);
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int r = 0; r < 16; r++) begin
          mr[z][r] = '0; mb[z][r] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          a = wa[k*4 +: 4];
          if (we[k] && !(z == 1 && a == 4'd0)) begin
            mr[z][a] = wd[k*64 +: 64];
            mb[z][a] = 1'b0;
          end
        end
        if (acc[z] && !(z == 1 && ia == 4'd0)) mb[z][ia] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    int          zi;
    logic        rst;
    logic [1:0]  we;
    logic [3:0]  wa0;
    logic [63:0] wd0;
    logic [3:0]  wa1;
    logic [63:0] wd1;
    logic        ie;
    logic [3:0]  ia;
    logic [3:0]  ra0;
    logic [63:0] xd;
    logic        xr;
    logic        xa;
    logic [4:0]  xc;
    logic        xf;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(int zi, logic r, logic [1:0] e,
    logic [3:0] a0, logic [63:0] d0_, logic [3:0] a1, logic [63:0] d1_,
    logic ie_, logic [3:0] ia_, logic [3:0] ra_,
    logic [63:0] xd, logic xr, logic xa, logic [4:0] xc, logic xf);
    vec_t v;
    v.zi = zi; v.rst = r; v.we = e; v.wa0 = a0; v.wd0 = d0_;
    v.wa1 = a1; v.wd1 = d1_; v.ie = ie_; v.ia = ia_; v.ra0 = ra_;
    v.xd = xd; v.xr = xr; v.xa = xa; v.xc = xc; v.xf = xf;
    tbl.push_back(v);
  endfunction

  initial begin
    int z;
    //   zi rst we  wa0 wd0      wa1 wd1    ie ia ra  xd       xr xa xc xf
    add(0, 0, 2'b01, 3, 64'hDEAD, 0, 0,     0, 0, 3,  64'hDEAD, 1, 0, 0, 0);
    add(0, 1, 2'b01, 3, 64'hDEAD, 0, 0,     0, 0, 3,  64'hDEAD, 1, 0, 0, 0);
    add(0, 0, 2'b00, 0, 0,        0, 0,     0, 0, 3,  64'h0,    1, 0, 0, 0);
    add(0, 0, 2'b11, 5, 64'h11,   5, 64'h22, 0, 0, 5, 64'h22,   1, 0, 0, 0);
    add(0, 0, 2'b00, 0, 0,        0, 0,     0, 0, 5,  64'h22,   1, 0, 0, 0);
    add(0, 0, 2'b00, 0, 0,        0, 0,     1, 7, 7,  64'h0,    1, 1, 0, 0);
    add(0, 0, 2'b00, 0, 0,        0, 0,     1, 7, 7,  64'h0,    0, 0, 1, 0);
    add(0, 0, 2'b01, 7, 64'h5,    0, 0,     0, 0, 7,  64'h5,    1, 0, 1, 0);
    add(0, 0, 2'b00, 0, 0,        0, 0,     0, 0, 7,  64'h5,    1, 0, 0, 0);
    add(0, 0, 2'b10, 0, 0,        2, 64'h77, 1, 2, 2, 64'h77,   1, 1, 0, 0);
    add(0, 0, 2'b00, 0, 0,        0, 0,     0, 0, 2,  64'h77,   0, 0, 1, 0);
    add(0, 0, 2'b01, 2, 64'h88,   0, 0,     1, 2, 2,  64'h88,   1, 0, 1, 0);
    add(0, 0, 2'b00, 0, 0,        0, 0,     0, 0, 2,  64'h88,   1, 0, 0, 0);
    add(0, 0, 2'b01, 15, 64'h1,   0, 0,     0, 0, 15, 64'h1,    1, 0, 0, 0);
    add(0, 0, 2'b01, 15, 64'h2,   0, 0,     0, 0, 15, 64'h2,    1, 0, 0, 1);
    add(0, 0, 2'b00, 0, 0,        0, 0,     0, 0, 15, 64'h2,    1, 0, 0, 0);
    add(1, 0, 2'b01, 0, 64'hFF,   0, 0,     0, 0, 0,  64'h0,    1, 0, 0, 0);
    add(1, 0, 2'b00, 0, 0,        0, 0,     1, 0, 0,  64'h0,    1, 1, 0, 0);
    add(1, 0, 2'b00, 0, 0,        0, 0,     0, 0, 0,  64'h0,    1, 0, 0, 0);

    rst = 1'b1; we = '0; wa = '0; wd = '0; ie = 1'b0; ia = '0; ra = '0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rd_data", o_rd[0][63:0], 64'h0);
    chk("reset rd_ready", 64'(o_rr[0]), 64'h3);
    chk("reset busy_count", 64'(o_cnt[0]), 64'h0);

    foreach (tbl[n]) begin
      rst = tbl[n].rst;
      we  = tbl[n].we;
      wa  = {tbl[n].wa1, tbl[n].wa0};
      wd  = {tbl[n].wd1, tbl[n].wd0};
      ie  = tbl[n].ie;
      ia  = tbl[n].ia;
      ra  = {tbl[n].ra0 + 4'd1, tbl[n].ra0};
      #1;
      z = tbl[n].zi;
      chk($sformatf("row%0d rd_data", n), o_rd[z][63:0], tbl[n].xd);
      chk($sformatf("row%0d rd_ready", n), 64'(o_rr[z][0]), 64'(tbl[n].xr));
      chk($sformatf("row%0d accept", n), 64'(o_acc[z]), 64'(tbl[n].xa));
      chk($sformatf("row%0d count", n), 64'(o_cnt[z]), 64'(tbl[n].xc));
      chk($sformatf("row%0d flag", n), 64'(o_flg[z]), 64'(tbl[n].xf));
      cycle();
    end

    rst = 1'b0; we = '0;
    for (int r = 0; r < 16; r++) begin
      ie = 1'b1; ia = 4'(r); ra = {4'(r), 4'(15 - r)};
      cycle();
    end
    ie = 1'b1; ia = 4'd5;
    #1;
    chk("full count d0", 64'(o_cnt[0]), 64'd16);
    chk("full count d1", 64'(o_cnt[1]), 64'd15);
    chk("full issue reject", 64'(o_acc[0]), 64'd0);
    chk("zero issue accept d1", 64'(o_acc[1] | 1'b0), 64'd0);
    cycle();
    ie = 1'b0;
    for (int j = 0; j < 8; j++) begin
      we = 2'b11;
      wa = {4'(2*j + 1), 4'(2*j)};
      wd = {64'(j + 100), 64'(j + 200)};
      ra = wa;
      cycle();
    end
    we = '0;
    #1;
    chk("drained count d0", 64'(o_cnt[0]), 64'd0);
    chk("drained count d1", 64'(o_cnt[1]), 64'd0);
    cycle();

    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = 2'($urandom);
      wa  = 8'($urandom);
      wd  = {$urandom, $urandom, $urandom, $urandom};
      ie  = 1'($urandom);
      ia  = 4'($urandom);
      ra  = ($urandom_range(0, 2) == 0) ? wa : 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
